// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode and control-field encodings for the multicycle sequencer
package mc_pkg;
  typedef logic [3:0] state_t;
  localparam state_t FETCH    = 4'd0;
  localparam state_t DECODE   = 4'd1;
  localparam state_t MEMADR   = 4'd2;
  localparam state_t MEMREAD  = 4'd3;
  localparam state_t MEMWB    = 4'd4;
  localparam state_t MEMWRITE = 4'd5;
  localparam state_t EXECR    = 4'd6;
  localparam state_t EXECI    = 4'd7;
  localparam state_t ALUWB    = 4'd8;
  localparam state_t BEQ      = 4'd9;
  localparam state_t JAL      = 4'd10;
  localparam state_t ILLEGAL  = 4'd11;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RD1   = 2'b10;
  localparam logic [1:0] SB_RD2 = 2'b00;
  localparam logic [1:0] SB_4   = 2'b01;
  localparam logic [1:0] SB_IMM = 2'b10;
  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_DATA   = 2'b01;
  localparam logic [1:0] RS_ALU    = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    return op == OP_STORE ? IMM_S : op == OP_BR ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive cycles spent waiting on mem_ready and flags the last allowed one
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);
  logic [7:0] cnt;
  // count while waiting, otherwise hold at zero so every wait state starts fresh
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= run ? cnt + 8'd1 : '0;
  assign expire = run && cnt == 8'(WAIT_MAX - 1);
endmodule

// File: rtl/multiciclo_fsm.sv
// multiciclo_fsm: RV64I multicycle control sequencer with ready handshake, timeout fault and instret
module multiciclo_fsm
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       MemSize,
  output logic             fault,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);
  state_t state, next;
  logic waiting, expire, pc_update, branch, ir_w, reg_w, mem_w;
  assign waiting = state == FETCH || state == MEMREAD || state == MEMWRITE;
  mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk(clk),
    .reset(reset),
    .run(waiting && !mem_ready),
    .expire(expire)
  );
  // next-state selection; a wait state leaves on ready or faults on its last allowed cycle
  always_comb begin
    next = ILLEGAL;
    case (state)
      FETCH:               next = mem_ready ? DECODE : expire ? ILLEGAL : FETCH;
      DECODE:              next = op == OP_LOAD || op == OP_STORE ? MEMADR :
                                  op == OP_R ? EXECR : op == OP_I ? EXECI :
                                  op == OP_BR && funct3 == 3'b000 ? BEQ :
                                  op == OP_JAL ? JAL : ILLEGAL;
      MEMADR:              next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:             next = mem_ready ? MEMWB : expire ? ILLEGAL : MEMREAD;
      MEMWRITE:            next = mem_ready ? FETCH : expire ? ILLEGAL : MEMWRITE;
      MEMWB, ALUWB, BEQ:   next = FETCH;
      EXECR, EXECI, JAL:   next = ALUWB;
      default:             next = ILLEGAL;
    endcase
  end
  // state register and retired-instruction counter; any return to FETCH retires one instruction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state   <= next;
      instret <= next == FETCH && state != FETCH ? instret + CNT_W'(1) : instret;
    end
  // Moore control decode; only the FETCH strobes follow the handshake
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RS_ALUOUT;
    ALUSrcA   = SA_PC;
    ALUSrcB   = SB_RD2;
    ALUOp     = ALU_ADD;
    case (state)
      FETCH:    begin ResultSrc = RS_ALU; ALUSrcB = SB_4; ir_w = mem_ready; pc_update = mem_ready; end
      DECODE:   begin ALUSrcA = SA_OLDPC; ALUSrcB = SB_IMM; end
      MEMADR:   begin ALUSrcA = SA_RD1; ALUSrcB = SB_IMM; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = RS_DATA; reg_w = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mem_w = 1'b1; end
      EXECR:    begin ALUSrcA = SA_RD1; ALUOp = ALU_FUNCT; end
      EXECI:    begin ALUSrcA = SA_RD1; ALUSrcB = SB_IMM; ALUOp = ALU_FUNCT; end
      ALUWB:    reg_w = 1'b1;
      BEQ:      begin ALUSrcA = SA_RD1; ALUOp = ALU_SUB; branch = 1'b1; end
      JAL:      begin ALUSrcA = SA_OLDPC; ALUSrcB = SB_4; pc_update = 1'b1; end
      default:  ;
    endcase
  end
  assign PCWrite   = reset && (pc_update || (branch && zero));
  assign IRWrite   = reset && ir_w;
  assign RegWrite  = reset && reg_w;
  assign MemWrite  = reset && mem_w;
  assign MemSize   = state == MEMADR || state == MEMREAD || state == MEMWRITE ? funct3[1:0] : 2'b11;
  assign ImmSrc    = imm_sel(op);
  assign fault     = state == ILLEGAL;
  assign state_dbg = state;
endmodule

// File: doc/multiciclo_fsm.md
Name: multiciclo_fsm

Overview:
Main sequencer for the RV64I multicycle datapath. It decodes opcode/funct3 and drives, state by state, the PC write, IR write, memory, register-file and mux-select controls. Memory accesses use a ready handshake with a bounded wait. It also keeps a retired-instruction counter and a sticky fault flag. It sits beside the ALU decoder and feeds the processor top.

Parameters:
WAIT_MAX, 15, max cycles a memory state waits for mem_ready before faulting (1..255)
CNT_W, 64, width of instret counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
op  in  7  Instr[6:0]
funct3  in  3  Instr[14:12]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  load PC
AdrSrc  out  1  0=PC, 1=Result to memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  load instruction register and OldPC
RegWrite  out  1  register-file write
ResultSrc  out  2  00=ALUOut reg, 01=data reg, 10=ALU result
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  out  2  00=RD2, 01=constant 4, 10=Imm
ImmSrc  out  3  000=I, 001=S, 010=B, 011=J
ALUOp  out  2  00=add, 01=sub, 10=decode funct
MemSize  out  2  funct3[1:0] in MEMADR/MEMREAD/MEMWRITE, else 11
fault  out  1  sticky: illegal opcode or memory timeout
instret  out  CNT_W  retired-instruction count
state_dbg  out  4  current state encoding

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, instret=0, fault=0, wait counter=0. All strobes are 0 while reset is held. Other outputs take the FETCH values.
- Outputs are Moore, decoded from state only. The one exception: PCWrite = PCUpdate | (Branch & zero).
- ImmSrc is decoded combinationally from op in every state: lw/ld/I-ALU→000, sw/sd→001, beq→010, jal→011, otherwise 000.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only in the cycle mem_ready=1; the FSM then moves to DECODE.
  - Otherwise it stays in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ (funct3 must be 000, else ILLEGAL)
  - 1101111 → JAL
  - any other op → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Goes to MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: ResultSrc=00, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH and retires.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until mem_ready. Then goes to FETCH and retires.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=10, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH and retires.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH and retires; taken when zero=1.
- JAL: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB (rd=PC+4) and retires in ALUWB.
- ILLEGAL: fault=1. All strobes are 0. The FSM stays in ILLEGAL until reset.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE; increments each cycle mem_ready=0 in those states.
  - Reaching WAIT_MAX with mem_ready=0 → ILLEGAL with fault=1.
  - If mem_ready=1 arrives in the cycle the counter hits WAIT_MAX, the handshake wins.
- instret:
  - Increments by 1 in the cycle a state exits to FETCH (MEMWB, MEMWRITE with ready, ALUWB, BEQ).
  - Wraps at 2^CNT_W-1→0.
  - The JAL→ALUWB path counts once.
- A reset during a wait state aborts the access immediately; no MemWrite pulse survives reset.
- Latencies, in states with zero-wait memory: R/I 4, ld 5, sd 4, beq 3, jal 4.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4-bit, FETCH=0 … ILLEGAL=11);
  - opcode localparams;
  - ALUOp, ALUSrcA/B, ResultSrc and ImmSrc encodings.
- Sub-module mc_wait_timer (counter, clear, expire) is instantiated once.
- The output decode stays in the FSM as a case on state.

Test Plan:
- Reset held 3 cycles then released, mem_ready=1, op=0110011 → states FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; instret=1 after 4 cycles.
- op=0000011, mem_ready low 3 cycles in MEMREAD → MEMREAD held 4 cycles, MemSize=funct3[1:0], MEMWB RegWrite, instret+1.
- op=1100011 funct3=000: zero=1 → PCWrite=1 in BEQ; zero=0 → PCWrite=0; funct3=001 → ILLEGAL, fault=1.
- mem_ready stuck 0 in FETCH with WAIT_MAX=15 → ILLEGAL after 15 cycles, fault=1, IRWrite never asserted; mem_ready=1 exactly at cycle 15 → DECODE.
- Reset asserted mid-MEMWRITE wait → MemWrite=0 asynchronously, state FETCH, instret=0, fault=0.
- instret preloaded near wrap (CNT_W=4), 2 retirements from 15 → reads 0 then 1.
